// File: rtl/core_ma.sv
// rtl/core_ma.sv - RV32 memory-access pipeline stage (EX/MEM -> MA/WB)
//
// Purpose: takes the EX/MEM entry, performs loads/stores over a word-wide
// data bus (cmd valid/ready + read-response strobe), steers store bytes and
// enables, sign/zero extends loads, and registers the MA/WB entry. ALU/CSR
// entries pass through in one cycle.
//
// Parameter: STORE_WAIT_ACK - 1: store completes on bus_rdata_valid,
//                             0: store completes on command acceptance.
// Optional build macro: CORE_MA_MISALIGN_EXC_EN - adds ma_exc_valid,
//   ma_exc_cause, ma_exc_tval and raises an exception instead of accessing
//   the bus for misaligned halfword/word accesses.
//
// Ports:
//   clk, rest (async active-low reset)
//   em_*  : EX/MEM entry in, em_ready out (combinational consume strobe)
//   mw_*  : registered MA/WB entry out, mw_valid one-cycle pulse
//   bus_* : cmd valid/ready, word address, write, wdata, byte_en,
//           rdata, rdata_valid
module core_ma #(
  parameter int STORE_WAIT_ACK = 0
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        em_valid,
  input  logic        em_start_handle,
  output logic        em_ready,
  input  logic [31:0] em_reg_data_mem_addr,
  input  logic [31:0] em_csr_data_mem_data,
  input  logic        em_mem_read,
  input  logic        em_mem_write,
  input  logic [2:0]  em_mem_op_type,
  input  logic [4:0]  em_rd,
  input  logic        em_reg_write,
  input  logic [11:0] em_csr,
  input  logic        em_csr_write,
  output logic        mw_valid,
  output logic [4:0]  mw_rd,
  output logic        mw_reg_write,
  output logic [31:0] mw_reg_write_data,
  output logic        mw_mem_data_valid,
  output logic [11:0] mw_csr,
  output logic        mw_csr_write,
  output logic [31:0] mw_csr_data,
  output logic        bus_cmd_valid,
  input  logic        bus_cmd_ready,
  output logic [31:0] bus_addr,
  output logic        bus_write,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byte_en,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rdata_valid
`ifdef CORE_MA_MISALIGN_EXC_EN
  ,
  output logic        ma_exc_valid,
  output logic [31:0] ma_exc_cause,
  output logic [31:0] ma_exc_tval
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RESP = 2'd2} state_t;
  state_t state, state_next;

  // em_start_handle carries no information this stage needs.
  logic unused_start_handle;
  assign unused_start_handle = em_start_handle;

  logic [1:0] lane;
  logic       size_b, size_h;
  logic       is_load, is_mem, misalign, mem_go, store_on_accept, fire;

  assign lane    = em_reg_data_mem_addr[1:0];
  assign size_b  = (em_mem_op_type[1:0] == 2'b00);
  assign size_h  = (em_mem_op_type[1:0] == 2'b01);
  // Read wins when both read and write are flagged.
  assign is_load = em_mem_read;
  assign is_mem  = em_mem_read | em_mem_write;

`ifdef CORE_MA_MISALIGN_EXC_EN
  assign misalign = is_mem & ((size_h & lane[0]) | (~size_b & ~size_h & (lane != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign mem_go          = em_valid & is_mem & ~misalign;
  assign store_on_accept = ~is_load & (STORE_WAIT_ACK == 0);

  // State register
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (mem_go) state_next = bus_cmd_ready ? (store_on_accept ? IDLE : RESP) : CMD;
      CMD:  if (bus_cmd_ready) state_next = store_on_accept ? IDLE : RESP;
      RESP: if (bus_rdata_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; held at zero while reset is asserted.
  always_comb begin
    bus_cmd_valid = 1'b0;
    em_ready      = 1'b0;
    if (rest) begin
      case (state)
        IDLE: begin
          bus_cmd_valid = mem_go;
          em_ready      = ~mem_go | (bus_cmd_ready & store_on_accept);
        end
        CMD: begin
          bus_cmd_valid = 1'b1;
          em_ready      = bus_cmd_ready & store_on_accept;
        end
        RESP:    em_ready = bus_rdata_valid;
        default: em_ready = 1'b0;
      endcase
    end
  end

  // Store lane steering; the em entry is held upstream until consumed, so
  // these stay stable while the command waits for acceptance.
  logic [31:0] wdata_s;
  logic [3:0]  be_s;
  always_comb begin
    wdata_s = em_csr_data_mem_data;
    be_s    = 4'b1111;
    if (size_b) begin
      wdata_s = {4{em_csr_data_mem_data[7:0]}};
      be_s    = 4'b0001 << lane;
    end else if (size_h) begin
      wdata_s = {2{em_csr_data_mem_data[15:0]}};
      be_s    = 4'b0011 << {lane[1], 1'b0};
    end
  end

  assign bus_addr    = bus_cmd_valid ? {em_reg_data_mem_addr[31:2], 2'b00} : 32'h0;
  assign bus_write   = bus_cmd_valid & ~is_load;
  assign bus_wdata   = (bus_cmd_valid & ~is_load) ? wdata_s : 32'h0;
  assign bus_byte_en = bus_cmd_valid ? be_s : 4'b0000;

  // Load extraction and extension; op_type[2] selects zero extension.
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sext;
  logic [31:0] load_v;
  always_comb begin
    case (lane)
      2'd0:    byte_v = bus_rdata[7:0];
      2'd1:    byte_v = bus_rdata[15:8];
      2'd2:    byte_v = bus_rdata[23:16];
      default: byte_v = bus_rdata[31:24];
    endcase
    half_v = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    sext   = ~em_mem_op_type[2];
    if (size_b)      load_v = {{24{sext & byte_v[7]}}, byte_v};
    else if (size_h) load_v = {{16{sext & half_v[15]}}, half_v};
    else             load_v = bus_rdata;
  end

  assign fire = em_valid & em_ready & ~misalign;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      mw_valid          <= 1'b0;
      mw_mem_data_valid <= 1'b0;
      mw_rd             <= 5'd0;
      mw_reg_write      <= 1'b0;
      mw_reg_write_data <= 32'h0;
      mw_csr            <= 12'h0;
      mw_csr_write      <= 1'b0;
      mw_csr_data       <= 32'h0;
    end else begin
      mw_valid          <= fire;
      mw_mem_data_valid <= fire;
      if (fire) begin
        mw_rd             <= em_rd;
        mw_reg_write      <= em_reg_write;
        mw_reg_write_data <= is_load ? load_v : em_reg_data_mem_addr;
        mw_csr            <= em_csr;
        mw_csr_write      <= em_csr_write;
        mw_csr_data       <= em_csr_data_mem_data;
      end
    end
  end

`ifdef CORE_MA_MISALIGN_EXC_EN
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      ma_exc_valid <= 1'b0;
      ma_exc_cause <= 32'h0;
      ma_exc_tval  <= 32'h0;
    end else begin
      ma_exc_valid <= em_valid & em_ready & misalign;
      if (em_valid & em_ready & misalign) begin
        ma_exc_cause <= is_load ? 32'd4 : 32'd6;
        ma_exc_tval  <= em_reg_data_mem_addr;
      end
    end
  end
`endif

endmodule

// File: tb/tb_core_ma.sv
// tb/tb_core_ma.sv - directed self-checking bench for core_ma
module tb_core_ma;

  logic        clk;
  logic        rest;
  logic        em_valid, em_start_handle, em_ready;
  logic [31:0] em_reg_data_mem_addr, em_csr_data_mem_data;
  logic        em_mem_read, em_mem_write;
  logic [2:0]  em_mem_op_type;
  logic [4:0]  em_rd;
  logic        em_reg_write;
  logic [11:0] em_csr;
  logic        em_csr_write;
  logic        mw_valid;
  logic [4:0]  mw_rd;
  logic        mw_reg_write;
  logic [31:0] mw_reg_write_data;
  logic        mw_mem_data_valid;
  logic [11:0] mw_csr;
  logic        mw_csr_write;
  logic [31:0] mw_csr_data;
  logic        bus_cmd_valid, bus_cmd_ready;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_rdata;
  logic        bus_rdata_valid;

  int passed = 0;
  int total  = 0;

  core_ma dut (
    .clk(clk), .rest(rest),
    .em_valid(em_valid), .em_start_handle(em_start_handle), .em_ready(em_ready),
    .em_reg_data_mem_addr(em_reg_data_mem_addr), .em_csr_data_mem_data(em_csr_data_mem_data),
    .em_mem_read(em_mem_read), .em_mem_write(em_mem_write), .em_mem_op_type(em_mem_op_type),
    .em_rd(em_rd), .em_reg_write(em_reg_write), .em_csr(em_csr), .em_csr_write(em_csr_write),
    .mw_valid(mw_valid), .mw_rd(mw_rd), .mw_reg_write(mw_reg_write),
    .mw_reg_write_data(mw_reg_write_data), .mw_mem_data_valid(mw_mem_data_valid),
    .mw_csr(mw_csr), .mw_csr_write(mw_csr_write), .mw_csr_data(mw_csr_data),
    .bus_cmd_valid(bus_cmd_valid), .bus_cmd_ready(bus_cmd_ready), .bus_addr(bus_addr),
    .bus_write(bus_write), .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en),
    .bus_rdata(bus_rdata), .bus_rdata_valid(bus_rdata_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  task automatic idle_inputs();
    em_valid = 0; em_start_handle = 0; em_reg_data_mem_addr = 0; em_csr_data_mem_data = 0;
    em_mem_read = 0; em_mem_write = 0; em_mem_op_type = 0; em_rd = 0; em_reg_write = 0;
    em_csr = 0; em_csr_write = 0; bus_cmd_ready = 0; bus_rdata = 0; bus_rdata_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rest = 0;
    #3;
    total++; if (mw_valid !== 1'b0) $display("FAIL reset_mw_valid got %0h exp 0", mw_valid); else passed++;
    total++; if (mw_reg_write_data !== 32'h0) $display("FAIL reset_mw_data got %08h exp 0", mw_reg_write_data); else passed++;
    total++; if (bus_cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid got %0h exp 0", bus_cmd_valid); else passed++;
    total++; if (em_ready !== 1'b0) $display("FAIL reset_em_ready got %0h exp 0", em_ready); else passed++;
    total++; if (bus_addr !== 32'h0) $display("FAIL reset_bus_addr got %08h exp 0", bus_addr); else passed++;
    @(posedge clk); #1;
    rest = 1;
  endtask

  task automatic test_alu();
    em_valid = 1; em_start_handle = 1; em_reg_data_mem_addr = 32'h1234; em_rd = 5; em_reg_write = 1;
    em_csr = 12'h305; em_csr_write = 1; em_csr_data_mem_data = 32'hCAFE0001;
    #1;
    total++; if (em_ready !== 1'b1) $display("FAIL alu_em_ready got %0h exp 1", em_ready); else passed++;
    total++; if (bus_cmd_valid !== 1'b0) $display("FAIL alu_cmd_valid got %0h exp 0", bus_cmd_valid); else passed++;
    @(posedge clk); #1;
    em_start_handle = 0;
    total++; if (mw_valid !== 1'b1) $display("FAIL alu_mw_valid got %0h exp 1", mw_valid); else passed++;
    total++; if (mw_rd !== 5'd5) $display("FAIL alu_mw_rd got %0d exp 5", mw_rd); else passed++;
    total++; if (mw_reg_write_data !== 32'h1234) $display("FAIL alu_mw_data got %08h exp 00001234", mw_reg_write_data); else passed++;
    total++; if (mw_mem_data_valid !== 1'b1) $display("FAIL alu_mem_data_valid got %0h exp 1", mw_mem_data_valid); else passed++;
    total++; if (mw_csr !== 12'h305) $display("FAIL alu_mw_csr got %03h exp 305", mw_csr); else passed++;
    total++; if (mw_csr_data !== 32'hCAFE0001) $display("FAIL alu_mw_csr_data got %08h exp cafe0001", mw_csr_data); else passed++;
    total++; if (mw_csr_write !== 1'b1) $display("FAIL alu_mw_csr_write got %0h exp 1", mw_csr_write); else passed++;
    idle_inputs();
    @(posedge clk); #1;
    total++; if (mw_valid !== 1'b0) $display("FAIL alu_pulse_end got %0h exp 0", mw_valid); else passed++;
    total++; if (mw_rd !== 5'd5) $display("FAIL alu_rd_hold got %0d exp 5", mw_rd); else passed++;
  endtask

  task automatic test_back_to_back();
    em_valid = 1; em_reg_data_mem_addr = 32'h11; em_rd = 1; em_reg_write = 1;
    @(posedge clk); #1;
    total++; if (mw_reg_write_data !== 32'h11 || mw_rd !== 5'd1) $display("FAIL b2b_first got %08h/%0d exp 00000011/1", mw_reg_write_data, mw_rd); else passed++;
    em_reg_data_mem_addr = 32'h22; em_rd = 2;
    @(posedge clk); #1;
    total++; if (mw_valid !== 1'b1) $display("FAIL b2b_second_valid got %0h exp 1", mw_valid); else passed++;
    total++; if (mw_reg_write_data !== 32'h22 || mw_rd !== 5'd2) $display("FAIL b2b_second got %08h/%0d exp 00000022/2", mw_reg_write_data, mw_rd); else passed++;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic load_vec(input string nm, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp_baddr, input logic [31:0] exp_data);
    em_valid = 1; em_mem_read = 1; em_mem_op_type = op; em_reg_data_mem_addr = addr;
    em_rd = 7; em_reg_write = 1; bus_cmd_ready = 1;
    #1;
    total++; if (bus_cmd_valid !== 1'b1 || bus_write !== 1'b0) $display("FAIL %s_cmd got v=%0h w=%0h exp v=1 w=0", nm, bus_cmd_valid, bus_write); else passed++;
    total++; if (bus_addr !== exp_baddr) $display("FAIL %s_addr got %08h exp %08h", nm, bus_addr, exp_baddr); else passed++;
    total++; if (em_ready !== 1'b0) $display("FAIL %s_ready_early got %0h exp 0", nm, em_ready); else passed++;
    @(posedge clk); #1;
    bus_cmd_ready = 0; bus_rdata = rdata; bus_rdata_valid = 1;
    #1;
    total++; if (bus_cmd_valid !== 1'b0 || em_ready !== 1'b1) $display("FAIL %s_resp got cv=%0h rdy=%0h exp cv=0 rdy=1", nm, bus_cmd_valid, em_ready); else passed++;
    @(posedge clk); #1;
    total++; if (mw_valid !== 1'b1 || mw_reg_write_data !== exp_data) $display("FAIL %s_data got v=%0h %08h exp v=1 %08h", nm, mw_valid, mw_reg_write_data, exp_data); else passed++;
    idle_inputs();
  endtask

  task automatic test_loads();
    load_vec("lb",  3'b000, 32'h103, 32'h80123456, 32'h100, 32'hFFFFFF80);
    load_vec("lbu", 3'b100, 32'h103, 32'h80123456, 32'h100, 32'h00000080);
    load_vec("lb1", 3'b000, 32'h101, 32'h00007F00, 32'h100, 32'h0000007F);
    load_vec("lh",  3'b001, 32'h102, 32'h80011234, 32'h100, 32'hFFFF8001);
    load_vec("lhu", 3'b101, 32'h100, 32'h0000F00F, 32'h100, 32'h0000F00F);
    load_vec("lw",  3'b010, 32'h104, 32'hDEADBEEF, 32'h104, 32'hDEADBEEF);
  endtask

  task automatic store_vec(input string nm, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_baddr, input logic [31:0] exp_wdata, input logic [3:0] exp_be);
    em_valid = 1; em_mem_write = 1; em_mem_op_type = op; em_reg_data_mem_addr = addr;
    em_csr_data_mem_data = data; bus_cmd_ready = 1;
    #1;
    total++; if (bus_cmd_valid !== 1'b1 || bus_write !== 1'b1) $display("FAIL %s_cmd got v=%0h w=%0h exp v=1 w=1", nm, bus_cmd_valid, bus_write); else passed++;
    total++; if (bus_addr !== exp_baddr) $display("FAIL %s_addr got %08h exp %08h", nm, bus_addr, exp_baddr); else passed++;
    total++; if (bus_wdata !== exp_wdata) $display("FAIL %s_wdata got %08h exp %08h", nm, bus_wdata, exp_wdata); else passed++;
    total++; if (bus_byte_en !== exp_be) $display("FAIL %s_be got %b exp %b", nm, bus_byte_en, exp_be); else passed++;
    total++; if (em_ready !== 1'b1) $display("FAIL %s_ready got %0h exp 1", nm, em_ready); else passed++;
    @(posedge clk); #1;
    total++; if (mw_valid !== 1'b1) $display("FAIL %s_mw_valid got %0h exp 1", nm, mw_valid); else passed++;
    idle_inputs();
  endtask

  task automatic test_stores();
    store_vec("sh_hi", 3'b001, 32'h202, 32'h1234ABCD, 32'h200, 32'hABCDABCD, 4'b1100);
    store_vec("sh_lo", 3'b001, 32'h200, 32'h5A5A1357, 32'h200, 32'h13571357, 4'b0011);
    store_vec("sb",    3'b000, 32'h301, 32'h000000EF, 32'h300, 32'hEFEFEFEF, 4'b0010);
    store_vec("sw",    3'b010, 32'h008, 32'h89ABCDEF, 32'h008, 32'h89ABCDEF, 4'b1111);
  endtask

  task automatic test_read_write_both();
    em_valid = 1; em_mem_read = 1; em_mem_write = 1; em_mem_op_type = 3'b010;
    em_reg_data_mem_addr = 32'h50; bus_cmd_ready = 1;
    #1;
    total++; if (bus_write !== 1'b0) $display("FAIL rw_both_write got %0h exp 0", bus_write); else passed++;
    @(posedge clk); #1;
    bus_cmd_ready = 0;
    total++; if (em_ready !== 1'b0) $display("FAIL rw_both_wait got %0h exp 0", em_ready); else passed++;
    bus_rdata = 32'h0BADF00D; bus_rdata_valid = 1;
    @(posedge clk); #1;
    total++; if (mw_reg_write_data !== 32'h0BADF00D) $display("FAIL rw_both_data got %08h exp 0badf00d", mw_reg_write_data); else passed++;
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int pulses;
    pulses = 0;
    em_valid = 1; em_mem_read = 1; em_mem_op_type = 3'b010; em_reg_data_mem_addr = 32'h40; em_rd = 3;
    em_reg_write = 1; bus_cmd_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus_cmd_valid !== 1'b1 || bus_addr !== 32'h40 || em_ready !== 1'b0)
        $display("FAIL bp_hold%0d got v=%0h a=%08h rdy=%0h exp v=1 a=00000040 rdy=0", i, bus_cmd_valid, bus_addr, em_ready);
      else passed++;
      @(posedge clk); #1;
      if (mw_valid === 1'b1) pulses++;
    end
    bus_cmd_ready = 1;
    #1;
    total++; if (bus_cmd_valid !== 1'b1 || bus_addr !== 32'h40) $display("FAIL bp_accept got v=%0h a=%08h exp v=1 a=00000040", bus_cmd_valid, bus_addr); else passed++;
    @(posedge clk); #1;
    if (mw_valid === 1'b1) pulses++;
    bus_cmd_ready = 0;
    bus_rdata = 32'h13579BDF; bus_rdata_valid = 1;
    @(posedge clk); #1;
    total++; if (mw_valid !== 1'b1 || mw_reg_write_data !== 32'h13579BDF) $display("FAIL bp_data got v=%0h %08h exp v=1 13579bdf", mw_valid, mw_reg_write_data); else passed++;
    if (mw_valid === 1'b1) pulses++;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (mw_valid === 1'b1) pulses++;
    end
    total++; if (pulses !== 1) $display("FAIL bp_pulse_count got %0d exp 1", pulses); else passed++;
  endtask

  task automatic test_reset_in_resp();
    em_valid = 1; em_mem_read = 1; em_mem_op_type = 3'b010; em_reg_data_mem_addr = 32'h80; bus_cmd_ready = 1;
    @(posedge clk); #1;
    bus_cmd_ready = 0;
    total++; if (em_ready !== 1'b0) $display("FAIL rst_resp_pending got %0h exp 0", em_ready); else passed++;
    idle_inputs();
    rest = 0;
    #1;
    total++; if (bus_cmd_valid !== 1'b0 || mw_valid !== 1'b0) $display("FAIL rst_resp_outputs got cv=%0h mv=%0h exp 0/0", bus_cmd_valid, mw_valid); else passed++;
    @(posedge clk); #1;
    rest = 1;
    bus_rdata = 32'hFFFF0000; bus_rdata_valid = 1;
    @(posedge clk); #1;
    total++; if (mw_valid !== 1'b0) $display("FAIL rst_stray_mw_valid got %0h exp 0", mw_valid); else passed++;
    bus_rdata_valid = 0;
    #1;
    total++; if (em_ready !== 1'b1 || bus_cmd_valid !== 1'b0) $display("FAIL rst_idle got rdy=%0h cv=%0h exp 1/0", em_ready, bus_cmd_valid); else passed++;
    em_valid = 1; em_mem_read = 1; em_mem_op_type = 3'b010; em_reg_data_mem_addr = 32'h84;
    #1;
    total++; if (bus_cmd_valid !== 1'b1 || bus_addr !== 32'h84) $display("FAIL rst_new_req got v=%0h a=%08h exp v=1 a=00000084", bus_cmd_valid, bus_addr); else passed++;
    bus_cmd_ready = 1;
    @(posedge clk); #1;
    bus_cmd_ready = 0; bus_rdata = 32'h00000042; bus_rdata_valid = 1;
    @(posedge clk); #1;
    total++; if (mw_valid !== 1'b1 || mw_reg_write_data !== 32'h42) $display("FAIL rst_new_data got v=%0h %08h exp v=1 00000042", mw_valid, mw_reg_write_data); else passed++;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_loads();
    test_stores();
    test_read_write_both();
    test_backpressure();
    test_reset_in_resp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
